// File: rtl/uart_led_cmd_pkg.sv
// Shared types and byte constants for the UART LED command controller.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GET_DATA = 2'd1,
    GET_MODE = 2'd2,
    REPLY    = 2'd3
  } state_t;

  localparam logic [7:0] OP_W  = 8'h57;
  localparam logic [7:0] OP_M  = 8'h4D;
  localparam logic [7:0] OP_R  = 8'h52;
  localparam logic [7:0] OP_B  = 8'h42;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_Q = 8'h3F;

  localparam logic [1:0] MODE_REG = 2'd0;
  localparam logic [1:0] MODE_CNT = 2'd1;
  localparam logic [1:0] MODE_RX  = 2'd2;

endpackage

// File: rtl/uart_led_cmd_if.sv
// Byte streams between the UART and the command block; slave is the command block side.
interface uart_led_cmd_if;
  logic [7:0] rx_tdata;
  logic       rx_tvalid;
  logic       rx_tready;
  logic [7:0] tx_tdata;
  logic       tx_tvalid;
  logic       tx_tready;

  modport master (
    output rx_tdata, rx_tvalid, tx_tready,
    input  rx_tready, tx_tdata, tx_tvalid
  );

  modport slave (
    input  rx_tdata, rx_tvalid, tx_tready,
    output rx_tready, tx_tdata, tx_tvalid
  );
endinterface

// File: rtl/uart_led_cmd_counter.sv
// Free-running prescaler plus wrapping LED_WIDTH counter; one count per PRESCALE cycles.
module led_prescale_counter #(
  parameter int LED_WIDTH = 8,
  parameter int PRESCALE  = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [LED_WIDTH-1:0] cnt
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]        pre_q, pre_d;
  logic [LED_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick;

  always_comb begin
    tick  = (pre_q == PW'(PRESCALE - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
    cnt_d = tick ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/uart_led_cmd.sv
// Byte-command controller: host writes/reads LEDs, selects LED source, reads buttons.
// Replies start the cycle after the command's last byte; rx is stalled while a reply drains.
module uart_led_cmd
  import uart_cmd_pkg::*;
#(
  parameter int                   LED_WIDTH      = 8,
  parameter int                   N_BTNS         = 2,
  parameter int                   PRESCALE       = 100_000_000,
  parameter int                   TIMEOUT_CYCLES = 1_000_000,
  parameter logic [LED_WIDTH-1:0] LED_INVERT     = '1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_led_cmd_if.slave        bus,
  input  logic [N_BTNS-1:0]    btn,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 cmd_err
);
  localparam int NBYTES = (LED_WIDTH + 7) / 8;
  localparam int RW     = NBYTES * 8;
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state_q, state_d;
  logic [LED_WIDTH-1:0] led_reg_q, led_reg_d;
  logic [RW-1:0]        wbuf_q, wbuf_d, wfull;
  logic [RW-1:0]        reply_q, reply_d;
  logic [2:0]           rem_q, rem_d;
  logic [1:0]           idx_q, idx_d;
  logic [1:0]           mode_q, mode_d;
  logic [7:0]           last_rx_q, last_rx_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic [N_BTNS-1:0]    btn_s1_q, btn_s2_q;
  logic                 cmd_err_q, cmd_err_d;
  logic                 acc, tmo_hit;
  logic [LED_WIDTH-1:0] cnt, src;

  led_prescale_counter #(.LED_WIDTH(LED_WIDTH), .PRESCALE(PRESCALE)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .cnt   (cnt)
  );

  assign bus.rx_tready = (state_q != REPLY);
  assign bus.tx_tvalid = (state_q == REPLY);
  assign bus.tx_tdata  = reply_q[7:0];
  assign cmd_err       = cmd_err_q;

  always_comb begin
    state_d   = state_q;
    led_reg_d = led_reg_q;
    wbuf_d    = wbuf_q;
    reply_d   = reply_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    last_rx_d = last_rx_q;
    tmo_d     = '0;
    cmd_err_d = 1'b0;
    wfull     = wbuf_q;
    acc       = bus.rx_tvalid && bus.rx_tready;
    tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    if (acc) last_rx_d = bus.rx_tdata;

    case (state_q)
      IDLE: if (acc) begin
        rem_d = 3'd1;
        case (bus.rx_tdata)
          OP_W: begin state_d = GET_DATA; idx_d = '0; end
          OP_M: state_d = GET_MODE;
          OP_R: begin state_d = REPLY; reply_d = RW'(led_reg_q); rem_d = 3'(NBYTES); end
          OP_B: begin state_d = REPLY; reply_d = RW'(btn_s2_q); end
          default: begin state_d = REPLY; reply_d = RW'(RSP_Q); cmd_err_d = 1'b1; end
        endcase
      end
      GET_DATA: if (acc) begin
        // Bytes collect in wbuf so partial writes never reach the LEDs.
        wfull[idx_q*8 +: 8] = bus.rx_tdata;
        wbuf_d = wfull;
        if (idx_q == 2'(NBYTES - 1)) begin
          led_reg_d = LED_WIDTH'(wfull);
          state_d   = REPLY;
          reply_d   = RW'(RSP_K);
          rem_d     = 3'd1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else if (tmo_hit) begin
        state_d   = IDLE;
        cmd_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      GET_MODE: if (acc) begin
        state_d = REPLY;
        rem_d   = 3'd1;
        if (bus.rx_tdata <= 8'd2) begin
          mode_d  = bus.rx_tdata[1:0];
          reply_d = RW'(RSP_K);
        end else begin
          reply_d   = RW'(RSP_Q);
          cmd_err_d = 1'b1;
        end
      end else if (tmo_hit) begin
        state_d   = IDLE;
        cmd_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
      REPLY: if (bus.tx_tready) begin
        reply_d = reply_q >> 8;
        rem_d   = rem_q - 1'b1;
        if (rem_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case (mode_q)
      MODE_REG: src = led_reg_q;
      MODE_RX:  src = LED_WIDTH'(32'(last_rx_q));
      default:  src = cnt;
    endcase
    leds = src ^ LED_INVERT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      led_reg_q <= '0;
      wbuf_q    <= '0;
      reply_q   <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      mode_q    <= MODE_CNT;
      last_rx_q <= '0;
      tmo_q     <= '0;
      btn_s1_q  <= '0;
      btn_s2_q  <= '0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      led_reg_q <= led_reg_d;
      wbuf_q    <= wbuf_d;
      reply_q   <= reply_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      last_rx_q <= last_rx_d;
      tmo_q     <= tmo_d;
      btn_s1_q  <= btn;
      btn_s2_q  <= btn_s1_q;
      cmd_err_q <= cmd_err_d;
    end
  end
endmodule

// File: tb/tb_uart_led_cmd.sv
// Directed bench for uart_led_cmd with a reply scoreboard and a throttled transmitter.
module tb_uart_led_cmd;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  btn = 2'b00;
  logic [11:0] leds;
  logic        cmd_err;
  logic        hold = 1'b0;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];

  uart_led_cmd_if bus ();

  uart_led_cmd #(
    .LED_WIDTH(12), .N_BTNS(2), .PRESCALE(4), .TIMEOUT_CYCLES(50), .LED_INVERT(12'hFFF)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .btn     (btn),
    .leds    (leds),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  // Reference counter: one tick every 4 cycles out of reset.
  logic [1:0]  m_pre;
  logic [11:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= 2'd0;
      m_cnt <= 12'd0;
    end else if (m_pre == 2'd3) begin
      m_pre <= 2'd0;
      m_cnt <= m_cnt + 12'd1;
    end else begin
      m_pre <= m_pre + 2'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every transmitted byte must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.tx_tvalid === 1'b1 && bus.tx_tready === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL tx_extra observed=%0h expected=none", bus.tx_tdata);
      end
      if (exp_q.size() != 0) chk("tx_byte", {24'b0, bus.tx_tdata}, {24'b0, exp_q.pop_front()});
    end
    if (rst_n === 1'b1 && cmd_err === 1'b1) err_cnt++;
  end

  initial begin
    bus.tx_tready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.tx_tready = hold ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_tdata  = b;
    bus.rx_tvalid = 1'b1;
    @(negedge clk);
    while (bus.rx_tready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("rx_accept", {31'b0, bus.rx_tready}, 32'd1);
    @(posedge clk);
    #1;
    bus.rx_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || bus.tx_tvalid !== 1'b0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    int n;
    bus.rx_tdata  = 8'h00;
    bus.rx_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_leds", {20'b0, leds}, 32'hFFF);
    chk("rst_tx_tvalid", {31'b0, bus.tx_tvalid}, 32'd0);
    chk("rst_tx_tdata", {24'b0, bus.tx_tdata}, 32'd0);
    chk("rst_rx_tready", {31'b0, bus.rx_tready}, 32'd1);
    chk("rst_cmd_err", {31'b0, cmd_err}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Counter mode right out of reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("cnt_leds", {20'b0, leds}, {20'b0, ~m_cnt});
    end
    n = 0;
    while (m_cnt !== 12'hFFF && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_top", {20'b0, leds}, 32'h000);
    n = 0;
    while (m_cnt !== 12'h000 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_wrap", {20'b0, leds}, 32'hFFF);
    @(posedge clk);
    #1;

    // Register mode and a two-byte write.
    exp_q.push_back(8'h4B);
    send(8'h4D);
    send(8'h00);
    wait_idle();
    exp_q.push_back(8'h4B);
    send(8'h57);
    send(8'h34);
    @(negedge clk);
    chk("partial_hidden", {20'b0, leds}, 32'hFFF);
    @(posedge clk);
    #1;
    send(8'h1A);
    wait_idle();
    chk("write_leds", {20'b0, leds}, 32'h5CB);
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h0A);
    send(8'h52);
    wait_idle();

    // Button read with a stalled transmitter.
    btn = 2'b10;
    repeat (4) @(posedge clk);
    #1;
    hold = 1'b1;
    exp_q.push_back(8'h02);
    send(8'h42);
    n = 0;
    while (bus.tx_tvalid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_tdata", {24'b0, bus.tx_tdata}, 32'h02);
      chk("stall_rx_tready", {31'b0, bus.rx_tready}, 32'd0);
      chk("stall_tvalid", {31'b0, bus.tx_tvalid}, 32'd1);
    end
    hold = 1'b0;
    wait_idle();

    // Unknown opcode and bad mode.
    base = err_cnt;
    exp_q.push_back(8'h3F);
    send(8'h58);
    wait_idle();
    chk("err_opcode", err_cnt - base, 32'd1);
    base = err_cnt;
    exp_q.push_back(8'h3F);
    send(8'h4D);
    send(8'h07);
    wait_idle();
    chk("err_mode", err_cnt - base, 32'd1);
    chk("mode_kept", {20'b0, leds}, 32'h5CB);

    // Timeout mid-write drops the partial data silently.
    base = err_cnt;
    send(8'h57);
    send(8'h55);
    repeat (60) @(negedge clk);
    chk("tmo_err", err_cnt - base, 32'd1);
    chk("tmo_rx_tready", {31'b0, bus.rx_tready}, 32'd1);
    chk("tmo_tx_tvalid", {31'b0, bus.tx_tvalid}, 32'd0);
    chk("tmo_leds", {20'b0, leds}, 32'h5CB);
    @(posedge clk);
    #1;
    exp_q.push_back(8'h34);
    exp_q.push_back(8'h0A);
    send(8'h52);
    wait_idle();

    // Last-byte mode, then reset while the reply is stalled.
    exp_q.push_back(8'h4B);
    send(8'h4D);
    send(8'h02);
    wait_idle();
    base = err_cnt;
    hold = 1'b1;
    exp_q.push_back(8'h3F);
    send(8'h5A);
    repeat (2) @(negedge clk);
    chk("rx_mode_leds", {20'b0, leds}, 32'hFA5);
    chk("reply_pending", {31'b0, bus.tx_tvalid}, 32'd1);
    chk("err_z", err_cnt - base, 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", {31'b0, bus.tx_tvalid}, 32'd0);
    chk("arst_tdata", {24'b0, bus.tx_tdata}, 32'd0);
    exp_q.delete();
    hold = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rx_tready", {31'b0, bus.rx_tready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
